// File: rtl/cfg_bitstream_tx.sv
// Byte-to-serial transmitter for the fabric configuration shift chain.
// Bytes arrive over valid/ready, shift out MSB-first, then a latch strobe and done pulse.
module cfg_bitstream_tx #(
  parameter int CHAIN_LEN = 144,
  parameter int DIV       = 1,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_byte_in,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_cfg_data,
  output logic             o_cfg_en,
  output logic             o_cfg_latch,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {StIdle, StWait, StShift, StLatch, StDone} state_e;

  state_e           r_state;
  logic [7:0]       r_shift;
  logic [3:0]       r_byte_cnt;
  logic [DIV_W-1:0] r_div;

  logic [31:0] w_remain;
  logic        w_last_bit;
  logic        w_en_next;

  assign w_remain   = 32'(CHAIN_LEN) - 32'(o_bit_cnt);
  assign w_last_bit = (32'(o_bit_cnt) + 32'd1) == 32'(CHAIN_LEN);
  // Divider is one cycle short of the enable cycle: raise cfg_en for the next cycle.
  assign w_en_next  = (32'(r_div) + 32'd1) == 32'(DIV - 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_div        <= '0;
      o_byte_ready <= 1'b0;
      o_cfg_data   <= 1'b0;
      o_cfg_en     <= 1'b0;
      o_cfg_latch  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_bit_cnt    <= '0;
    end else begin
      o_cfg_en    <= 1'b0;
      o_cfg_latch <= 1'b0;
      o_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state      <= StWait;
            o_bit_cnt    <= '0;
            o_byte_ready <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        StWait: begin
          if (i_byte_valid) begin
            r_state      <= StShift;
            r_shift      <= i_byte_in;
            r_byte_cnt   <= (w_remain >= 32'd8) ? 4'd8 : w_remain[3:0];
            r_div        <= '0;
            o_byte_ready <= 1'b0;
            o_cfg_data   <= i_byte_in[7];
            o_cfg_en     <= (DIV == 1);
          end
        end
        StShift: begin
          if (o_cfg_en) begin
            r_shift    <= {r_shift[6:0], 1'b0};
            r_byte_cnt <= r_byte_cnt - 4'd1;
            r_div      <= '0;
            o_bit_cnt  <= o_bit_cnt + CNT_W'(1);
            if (r_byte_cnt == 4'd1) begin
              o_cfg_data <= 1'b0;
              if (w_last_bit) begin
                r_state     <= StLatch;
                o_cfg_latch <= 1'b1;
              end else begin
                r_state      <= StWait;
                o_byte_ready <= 1'b1;
              end
            end else begin
              o_cfg_data <= r_shift[6];
              o_cfg_en   <= (DIV == 1);
            end
          end else begin
            r_div    <= r_div + DIV_W'(1);
            o_cfg_en <= w_en_next;
          end
        end
        StLatch: begin
          r_state <= StDone;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
